// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, prefetches words into a small FIFO
// and hands them to IF/ID over valid/ready. Define IFETCH_HALT_DETECT_EN to stop fetch on HALT_WORD.
module ifetch_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [6:0]             imem_addr,
    input  logic [31:0]            imem_data,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_q, head_d, new_entry_c;
    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic            push_c, pop_c, halt_hit_c;

    // Redirect target low bits are ignored by design.
    logic [1:0]      unused_rpc;
    assign unused_rpc = redirect_pc[1:0];

`ifndef IFETCH_HALT_DETECT_EN
    logic            unused_halt;
    assign unused_halt = halt_hit_c;
`endif

    assign new_entry_c = {pc_q, imem_data};

    // Next-state: redirect flushes and restarts; otherwise push/pop with head bypass.
    always_comb begin
        pop_c      = valid_q & out_ready;
        push_c     = (state_q == RUN) & ~redirect_valid & ((count_q < CW'(DEPTH)) | pop_c);
        halt_hit_c = push_c & (imem_data == HALT_WORD);
        state_d    = state_q;
        pc_d       = pc_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        valid_d    = valid_q;
        head_d     = head_q;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = {redirect_pc[31:2], 2'b00};
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            if (push_c) begin
                pc_d = pc_q + 32'd4;
                wr_d = wr_q + AW'(1);
`ifdef IFETCH_HALT_DETECT_EN
                if (halt_hit_c) begin
                    state_d = HALT;
                end
`endif
            end
            if (pop_c) begin
                rd_d = rd_q + AW'(1);
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
            valid_d = (count_d != '0);
            // The new head may be the word being written on this very edge.
            if (valid_d) begin
                head_d = (push_c && (rd_d == wr_q)) ? new_entry_c : mem[rd_d];
            end
        end
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            halted_q <= halted_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_q] <= new_entry_c;
        end
    end

    assign imem_addr  = pc_q[8:2];
    assign out_valid  = valid_q;
    assign out_instr  = head_q.instr;
    assign out_pc     = head_q.pc;
    assign fifo_count = count_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: cycle table plus an ordered scoreboard of expected {pc, instr}.
module tb_ifetch_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic        halted;

    logic [31:0] imem [128];
    assign imem_data = imem[imem_addr];

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000),
        .HALT_WORD(HALT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_ready(out_ready),
        .fifo_count(fifo_count),
        .halted(halted)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic        rdy;
        logic        rdv;
        logic [31:0] rpc;
        logic        ev;
        logic [2:0]  ec;
        logic [6:0]  ea;
        logic        cp;
        logic [31:0] epc;
    } vec_t;

    exp_t sbq [$];
    vec_t vecs [18];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    int   p0;

    function automatic vec_t mk(input logic rdy, input logic rdv, input logic [31:0] rpc,
                                input logic ev, input logic [2:0] ec, input logic [6:0] ea,
                                input logic cp, input logic [31:0] epc);
        vec_t v;
        v.rdy = rdy; v.rdv = rdv; v.rpc = rpc; v.ev = ev;
        v.ec = ec; v.ea = ea; v.cp = cp; v.epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push_run(input logic [31:0] start, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            sbq.push_back({a, imem[a[8:2]]});
        end
    endtask

    // Drive one cycle of inputs, then at the falling edge score any handshake.
    task automatic apply(input logic rdy, input logic rdv, input logic [31:0] rpc);
        exp_t e;
        out_ready      = rdy;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        @(negedge clk);
        if (out_valid && out_ready) begin
            pops++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no output", out_pc);
            end else begin
                e = sbq.pop_front();
                check("sb_pc", out_pc, e.pc);
                check("sb_instr", out_instr, e.instr);
            end
        end
        if (rdv) begin
            sbq.delete();
            sb_push_run({rpc[31:2], 2'b00}, 16);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_pc"}, out_pc, 32'd0);
        check({tag, "_instr"}, out_instr, 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 128; k++) imem[k] = 32'h1000_0000 + 32'(k);
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 3'd0, 7'h00, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 3'd1, 7'h01, 1'b1, 32'h0);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 3'd2, 7'h02, 1'b1, 32'h0);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 3'd3, 7'h03, 1'b1, 32'h0);
        for (int i = 4; i < 10; i++)
            vecs[i] = mk(1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 7'h04, 1'b1, 32'h0);
        vecs[10] = mk(1'b1, 1'b0, 32'h0,  1'b1, 3'd4, 7'h04, 1'b1, 32'h0);
        vecs[11] = mk(1'b1, 1'b0, 32'h0,  1'b1, 3'd4, 7'h05, 1'b1, 32'h4);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,  1'b1, 3'd4, 7'h06, 1'b1, 32'h8);
        vecs[13] = mk(1'b1, 1'b0, 32'h0,  1'b1, 3'd4, 7'h07, 1'b1, 32'hC);
        vecs[14] = mk(1'b1, 1'b1, 32'h43, 1'b1, 3'd4, 7'h08, 1'b1, 32'h10);
        vecs[15] = mk(1'b1, 1'b0, 32'h0,  1'b0, 3'd0, 7'h10, 1'b0, 32'h0);
        vecs[16] = mk(1'b1, 1'b0, 32'h0,  1'b1, 3'd1, 7'h11, 1'b1, 32'h40);
        vecs[17] = mk(1'b1, 1'b0, 32'h0,  1'b1, 3'd1, 7'h12, 1'b1, 32'h44);

        rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1 rst = 1'b1;
        #2 check_reset_state("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb_push_run(32'h0, 16);

        // Fill to saturation, drain with push+pop at full, then misaligned redirect.
        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].rdy, vecs[i].rdv, vecs[i].rpc);
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].ec));
            check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].ea));
            if (vecs[i].cp) check($sformatf("v%0d_pc", i), out_pc, vecs[i].epc);
            advance();
        end

        // Fetch across word 127 back to word 0 of the memory.
        apply(1'b1, 1'b1, 32'h1F8); advance();
        p0 = pops;
        apply(1'b1, 1'b0, 32'h0); check("wrap_addr0", 32'(imem_addr), 32'd126);
        check("wrap_valid0", 32'(out_valid), 32'd0); advance();
        apply(1'b1, 1'b0, 32'h0); check("wrap_addr1", 32'(imem_addr), 32'd127); advance();
        apply(1'b1, 1'b0, 32'h0); check("wrap_addr2", 32'(imem_addr), 32'd0); advance();
        apply(1'b1, 1'b0, 32'h0); check("wrap_addr3", 32'(imem_addr), 32'd1); advance();
        apply(1'b1, 1'b0, 32'h0); advance();
        check("wrap_pops", 32'(pops - p0), 32'd4);

        // Asynchronous reset with three entries held.
        apply(1'b0, 1'b1, 32'h100); advance();
        apply(1'b0, 1'b0, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0); advance();
        apply(1'b0, 1'b0, 32'h0);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        check("pre_rst_pc", out_pc, 32'h100);
        #2 rst = 1'b1;
        #1 check_reset_state("async_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sbq.delete();
        sb_push_run(32'h0, 16);
        p0 = pops;
        apply(1'b1, 1'b0, 32'h0);
        check("restart_valid0", 32'(out_valid), 32'd0);
        check("restart_addr0", 32'(imem_addr), 32'd0); advance();
        apply(1'b1, 1'b0, 32'h0);
        check("restart_valid1", 32'(out_valid), 32'd1);
        check("restart_pc1", out_pc, 32'h0); advance();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b0, 32'h0); advance();
        end
        check("restart_pops", 32'(pops - p0), 32'd6);

        // HALT_WORD at word 3, then redirect to 0x20.
        rst = 1'b1;
        imem[3] = HALT_W;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sbq.delete();
        sb_push_run(32'h0, 16);
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b0, 32'h0); advance();
        end
`ifdef IFETCH_HALT_DETECT_EN
        check("halt_pops", 32'(pops - p0), 32'd4);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(out_valid), 32'd0);
        check("halt_addr", 32'(imem_addr), 32'd4);
        check("halt_count", 32'(fifo_count), 32'd0);
`else
        check("nohalt_pops", 32'(pops - p0), 32'd9);
        check("nohalt_halted", 32'(halted), 32'd0);
`endif
        apply(1'b1, 1'b1, 32'h20); advance();
        p0 = pops;
        apply(1'b1, 1'b0, 32'h0);
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_addr", 32'(imem_addr), 32'h8); advance();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 32'h0); advance();
        end
        check("resume_pops", 32'(pops - p0), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
